// File: rtl/xup_tri_bus_reader.sv
`default_nettype none
// ============================================================================
// Module   : xup_tri_bus_reader
// Purpose  : Receiving end of a shared tri-state bus. Grants one source at a
//            time (round-robin), holds its driver enable for SETTLE cycles,
//            samples the resolved bus, then offers the word downstream over a
//            valid/ready handshake.
// Ports    : clk      - rising-edge clock
//            reset    - asynchronous active-high reset
//            req      - per-source request (level)
//            bus_in   - resolved shared bus, sampled on the capture edge
//            en       - registered one-hot driver enables
//            data_out - captured bus word
//            src_id   - index of the source that drove data_out
//            valid    - data_out/src_id hold a captured word
//            ready    - consumer accepts when valid && ready
// Revision : 1.0 - initial release
// ============================================================================
module xup_tri_bus_reader #(
  parameter int SIZE    = 4,
  parameter int NUM_SRC = 4,
  parameter int SETTLE  = 3
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [NUM_SRC-1:0]                              req,
  input  logic [SIZE-1:0]                                 bus_in,
  output logic [NUM_SRC-1:0]                              en,
  output logic [SIZE-1:0]                                 data_out,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] src_id,
  output logic                                            valid,
  input  logic                                            ready
);

  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDW:0]  C_NUM_SRC   = (IDW+1)'(NUM_SRC);
  localparam logic [CW-1:0] C_CNT_LAST  = CW'(SETTLE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDW-1:0]     ptr_q,   ptr_d;
  logic [IDW-1:0]     sel_q,   sel_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic [NUM_SRC-1:0] en_q,    en_d;
  logic [SIZE-1:0]    data_q,  data_d;
  logic [IDW-1:0]     src_q,   src_d;
  logic               valid_q, valid_d;

  // Round-robin arbiter: rotate req so ptr sits at bit 0, take the lowest set
  // bit, then rotate the offset back into an absolute source index.
  logic [NUM_SRC-1:0] req_win;
  logic [IDW-1:0]     arb_off;
  logic [IDW:0]       arb_sum;
  logic [IDW-1:0]     arb_sel;
  logic [IDW:0]       inc_sum;
  logic [IDW-1:0]     sel_next;

  always_comb begin
    req_win = NUM_SRC'({req, req} >> ptr_q);
    arb_off = '0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (req_win[j]) arb_off = IDW'(j);
    end
    arb_sum = {1'b0, ptr_q} + {1'b0, arb_off};
    if (arb_sum >= C_NUM_SRC) arb_sum = arb_sum - C_NUM_SRC;
    arb_sel = arb_sum[IDW-1:0];

    // Pointer for the next arbitration: one past the source just served.
    inc_sum = {1'b0, sel_q} + (IDW+1)'(1);
    if (inc_sum >= C_NUM_SRC) inc_sum = '0;
    sel_next = inc_sum[IDW-1:0];
  end

  // State register and all other flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req != '0)           state_d = S_DRIVE;
      S_DRIVE: if (cnt_q == C_CNT_LAST) state_d = S_HOLD;
      S_HOLD:  if (ready)               state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // Registered-output / datapath next values.
  always_comb begin
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        en_d    = '0;
        valid_d = 1'b0;
        if (req != '0) begin
          sel_d = arb_sel;
          en_d  = NUM_SRC'(1) << arb_sel;
          cnt_d = '0;
        end
      end
      S_DRIVE: begin
        cnt_d = cnt_q + CW'(1);
        // Sample while the enable is still asserted, drop it on the same edge.
        if (cnt_q == C_CNT_LAST) begin
          data_d  = bus_in;
          src_d   = sel_q;
          valid_d = 1'b1;
          en_d    = '0;
        end
      end
      S_HOLD: begin
        en_d = '0;
        if (ready) begin
          valid_d = 1'b0;
          ptr_d   = sel_next;
        end
      end
      default: begin
        en_d    = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign en       = en_q;
  assign data_out = data_q;
  assign src_id   = src_q;
  assign valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_xup_tri_bus_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_xup_tri_bus_reader
// Purpose  : Directed self-checking bench for xup_tri_bus_reader
//            (SIZE=4, NUM_SRC=4, SETTLE=3). Each source's buffer is modelled
//            by driving its value onto bus_in while its enable is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xup_tri_bus_reader;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] bus_in;
  logic [3:0] en;
  logic [3:0] data_out;
  logic [1:0] src_id;
  logic       valid;
  logic       ready;

  logic [3:0] src_val [4];

  int n_checks = 0;
  int n_fail   = 0;
  int multi_en = 0;

  xup_tri_bus_reader #(
    .SIZE    (4),
    .NUM_SRC (4),
    .SETTLE  (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .bus_in   (bus_in),
    .en       (en),
    .data_out (data_out),
    .src_id   (src_id),
    .valid    (valid),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Resolved bus: the enabled source's buffer drives it, otherwise 0.
  always_comb begin
    bus_in = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) bus_in = src_val[i];
    end
  end

  always @(negedge clk) begin
    if (!reset && !$onehot0(en)) multi_en++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(output int zeros);
    int n;
    zeros = 0;
    n = 0;
    while (en == 4'b0 && n < 50) begin
      zeros++;
      tick();
      n++;
    end
    if (en == 4'b0) check("wait_en_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (valid !== 1'b1) check("wait_valid_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int zeros;
    int cnt;
    int exp_src;

    reset = 1'b1;
    req   = 4'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) src_val[i] = 4'(i + 5);
    src_val[2] = 4'hA;

    // ---- reset values ----
    #12;
    check("rst_en",    32'(en),       32'h0);
    check("rst_valid", 32'(valid),    32'h0);
    check("rst_data",  32'(data_out), 32'h0);
    check("rst_src",   32'(src_id),   32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // ---- single grant of source 2 ----
    req = 4'b0100;
    tick();
    check("t1_en_c1", 32'(en), 32'b0100);
    req = 4'b0000;
    tick();
    check("t1_en_c2", 32'(en), 32'b0100);
    tick();
    check("t1_en_c3", 32'(en), 32'b0100);
    tick();
    check("t1_en_off",  32'(en),       32'h0);
    check("t1_valid",   32'(valid),    32'h1);
    check("t1_data",    32'(data_out), 32'hA);
    check("t1_src",     32'(src_id),   32'd2);
    tick();
    check("t1_valid_pulse", 32'(valid), 32'h0);
    check("t1_en_idle",     32'(en),    32'h0);

    // ---- round robin over all four sources from a fresh reset ----
    @(negedge clk);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    src_val[2] = 4'h7;
    req = 4'b1111;
    ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_src = g % 4;
      wait_en(zeros);
      check($sformatf("t2_grant%0d", g), 32'(en), 32'(4'b1 << exp_src));
      if (g > 0) check($sformatf("t2_gap%0d", g), 32'(zeros), 32'd2);
      if (g == 4) begin
        ready = 1'b0;
        req   = 4'b0011;
      end
      wait_valid();
      check($sformatf("t2_data%0d", g), 32'(data_out), 32'(exp_src + 5));
      check($sformatf("t2_src%0d", g),  32'(src_id),   32'(exp_src));
    end

    // ---- consumer back-pressure: HOLD for 10 cycles ----
    for (int c = 0; c < 10; c++) begin
      check("t3_valid_hold", 32'(valid),    32'h1);
      check("t3_data_hold",  32'(data_out), 32'h5);
      check("t3_en_hold",    32'(en),       32'h0);
      tick();
    end
    ready = 1'b1;
    tick();
    check("t3_valid_done", 32'(valid), 32'h0);
    check("t3_en_idle",    32'(en),    32'h0);
    tick();
    check("t3_grant_src1", 32'(en), 32'b0010);

    // ---- pointer wrap: serve source 3, then 0 wins over 3 ----
    req = 4'b1000;
    wait_valid();
    check("t4_data1", 32'(data_out), 32'h6);
    check("t4_src1",  32'(src_id),   32'd1);
    wait_en(zeros);
    check("t4_grant3", 32'(en), 32'b1000);
    req = 4'b1001;
    wait_valid();
    check("t4_data3", 32'(data_out), 32'h8);
    check("t4_src3",  32'(src_id),   32'd3);
    wait_en(zeros);
    check("t4_grant0_wrap", 32'(en), 32'b0001);
    req = 4'b0000;

    // ---- single-cycle request still completes the grant ----
    wait_valid();
    check("t5_src0", 32'(src_id), 32'd0);
    tick();
    tick();
    req = 4'b0010;
    tick();
    check("t5_en_first", 32'(en), 32'b0010);
    req = 4'b0000;
    cnt = 1;
    for (int n = 0; n < 20 && valid !== 1'b1; n++) begin
      tick();
      if (en == 4'b0010) cnt++;
    end
    check("t5_en_cycles", 32'(cnt),      32'd3);
    check("t5_data",      32'(data_out), 32'h6);
    check("t5_src",       32'(src_id),   32'd1);
    tick();
    check("t5_valid_drop", 32'(valid), 32'h0);
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (en != 4'b0 || valid) cnt++;
    end
    check("t5_no_regrant", 32'(cnt), 32'd0);

    // ---- reset in the middle of DRIVE ----
    req = 4'b0100;
    tick();
    check("t6_drive_c1", 32'(en), 32'b0100);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_en",    32'(en),    32'h0);
    check("t6_async_valid", 32'(valid), 32'h0);
    req = 4'b0101;
    tick();
    reset = 1'b0;
    tick();
    check("t6_grant_ptr0", 32'(en), 32'b0001);
    ready = 1'b0;
    wait_valid();
    check("t6_data", 32'(data_out), 32'h5);
    check("t6_src",  32'(src_id),   32'd0);

    // ---- reset in the middle of HOLD discards the word ----
    #2;
    reset = 1'b1;
    #1;
    check("t7_async_valid", 32'(valid),    32'h0);
    check("t7_async_data",  32'(data_out), 32'h0);
    check("t7_async_src",   32'(src_id),   32'h0);
    req   = 4'b0110;
    ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("t7_grant_after_rst", 32'(en), 32'b0010);
    req = 4'b0000;

    check("onehot_en", 32'(multi_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
